alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Byte-stream command sequencer between the UART byte link and the ALU datapath (incl. logical_operation).
//   Assembles opcode+operand frames from RX bytes, drives the ALU, captures the result, and streams it
//   back MSB-first over a valid/ready TX byte interface. One command in flight; overrun and timeout are policed.
// PARAMETERS
//   N          16      ALU operand/result width; must be a multiple of 8; NB = N/8 bytes per operand
//   TIMEOUT    1000    max idle cycles between bytes inside a frame before the frame is discarded
//   MAX_OPCODE 6       highest legal opcode; larger values are rejected
//   ERR_BYTE   8'hEE   single-byte response sent for a rejected frame
// PORTS
//   clk         in   1    clock; all state on rising edge
//   rst_n       in   1    asynchronous active-low reset
//   rx_data     in   8    received byte
//   rx_valid    in   1    1-cycle strobe, rx_data valid; no backpressure
//   tx_data     out  8    response byte
//   tx_valid    out  1    response byte valid
//   tx_ready    in   1    TX accepts byte when tx_valid&&tx_ready
//   alu_opcode  out  4    opcode to ALU
//   alu_a       out  N    operand A to ALU
//   alu_b       out  N    operand B to ALU
//   alu_out     in   N    ALU result (combinational from alu_*)
//   busy        out  1    high in every state except IDLE
//   frame_err   out  1    1-cycle pulse on timeout, overrun, bad opcode or bad checksum
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, tx_valid=0, tx_data=0, alu_opcode/alu_a/alu_b=0, busy=0,
//     frame_err=0, counters=0. Reset mid-frame or mid-response discards everything; no partial output.
//   - Frame: opcode byte, A (NB bytes MSB-first), B (NB bytes MSB-first). All bytes are always consumed.
//   - FSM: IDLE -(rx_valid)-> GET_A -(NB bytes)-> GET_B -(NB bytes)-> EXEC (1 cycle) -> RESP -> IDLE.
//   - alu_opcode loads on opcode byte; alu_a/alu_b shift in bytes; all hold after the response until the next frame.
//   - Opcode > MAX_OPCODE: flagged, frame still consumed; frame_err pulses in EXEC; response is ERR_BYTE only.
//   - Latency: last operand byte accepted in cycle t -> EXEC in t+1, alu_out registered at end of t+1,
//     tx_valid=1 with first byte in t+2.
//   - RESP: NB result bytes MSB-first; tx_data stable while tx_valid&&!tx_ready; byte index advances on
//     handshake; after final handshake tx_valid=0 and state=IDLE next cycle; back-to-back handshakes allowed.
//   - Timeout: idle counter cleared on each accepted byte, counts only in GET_A/GET_B; after TIMEOUT cycles
//     with no rx_valid -> IDLE, frame_err pulse. rx_valid in the same cycle as expiry: byte wins, counter clears.
//   - Overrun: rx_valid in EXEC or RESP -> byte dropped, frame_err pulse, response unaffected.
//   - rx_valid in the cycle RESP exits to IDLE is an overrun (dropped); first accepted byte is one cycle later.
// CONFIGURATION
//   ALU_SEQ_CHECKSUM_EN defined: frame carries one extra trailing byte (GET_CS state) = XOR of all preceding
//     frame bytes; mismatch -> ERR_BYTE response + frame_err pulse in EXEC. Valid result response carries
//     an extra trailing byte = XOR of the NB result bytes. ERR_BYTE response is never followed by a checksum.
//   Not defined: no checksum byte in either direction; GET_CS state and checksum logic absent.
// TESTING (N=16, checksum off unless stated)
//   1. rx 00 F0 F0 0F FF (AND) -> tx 00 F0; tx_valid exactly 2 cycles after last rx byte; busy low after.
//   2. rx 06 12 34 00 00 (NOT) -> tx ED CB; alu_a=16'h1234 held after completion.
//   3. rx 09 11 22 33 44 -> single tx EE, frame_err 1 pulse; next frame 01 00 0F 00 F0 -> tx 00 FF.
//   4. rx 01 AB then silence TIMEOUT cycles -> frame_err pulse, busy=0; then 02 FF 00 0F 0F -> tx F0 0F.
//   5. tx_ready low 5 cycles in RESP -> tx_data stable; rx byte during RESP -> dropped, frame_err pulse.
//   6. rst_n low mid-RESP -> tx_valid=0, alu_*=0, busy=0 immediately; with ALU_SEQ_CHECKSUM_EN,
//      rx 00 F0 F0 0F FF F0 -> tx 00 F0 F0; bad checksum byte 00 -> tx EE.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer between a UART byte link and the ALU datapath.
// Define ALU_SEQ_CHECKSUM_EN to add XOR checksum bytes to frames and responses.
module alu_cmd_sequencer #(
    parameter int          N          = 16,
    parameter int          TIMEOUT    = 1000,
    parameter int          MAX_OPCODE = 6,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [3:0]   alu_opcode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    output logic         busy,
    output logic         frame_err
);

    localparam int NB = N / 8;
    localparam int BW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef ALU_SEQ_CHECKSUM_EN
    localparam int RB = NB + 1;
`else
    localparam int RB = NB;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GET_A  = 3'd1;
    localparam logic [2:0] S_GET_B  = 3'd2;
`ifdef ALU_SEQ_CHECKSUM_EN
    localparam logic [2:0] S_GET_CS = 3'd3;
`endif
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]    state;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] rem;
    logic [TW-1:0] idle;
    logic          bad_op;
    logic [N-1:0]  res;
    logic [N-1:0]  nxt;
    logic          last;
    logic          err;

`ifdef ALU_SEQ_CHECKSUM_EN
    logic [7:0]    csx;
    logic [7:0]    rcs;
    logic          cs_bad;

    function automatic logic [7:0] xor_bytes(input logic [N-1:0] v);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < NB; i++) x = x ^ v[i*8 +: 8];
        return x;
    endfunction

    assign err = bad_op | cs_bad;
`else
    assign err = bad_op;
`endif

    assign busy = (state != S_IDLE);
    assign last = (bcnt == BW'(NB - 1));
    assign nxt  = res << 8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bcnt       <= '0;
            rem        <= '0;
            idle       <= '0;
            bad_op     <= 1'b0;
            res        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            frame_err  <= 1'b0;
`ifdef ALU_SEQ_CHECKSUM_EN
            csx        <= '0;
            rcs        <= '0;
            cs_bad     <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    idle <= '0;
                    if (rx_valid) begin
                        alu_opcode <= rx_data[3:0];
                        bad_op     <= (rx_data > 8'(MAX_OPCODE));
                        bcnt       <= '0;
                        state      <= S_GET_A;
`ifdef ALU_SEQ_CHECKSUM_EN
                        csx        <= rx_data;
`endif
                    end
                end
                S_GET_A,
`ifdef ALU_SEQ_CHECKSUM_EN
                S_GET_CS,
`endif
                S_GET_B: begin
                    if (rx_valid) begin
                        idle <= '0;
                        bcnt <= bcnt + BW'(1);
`ifdef ALU_SEQ_CHECKSUM_EN
                        csx  <= csx ^ rx_data;
`endif
                        if (state == S_GET_A) begin
                            alu_a <= (alu_a << 8) | N'(rx_data);
                            if (last) begin
                                bcnt  <= '0;
                                state <= S_GET_B;
                            end
                        end else if (state == S_GET_B) begin
                            alu_b <= (alu_b << 8) | N'(rx_data);
                            if (last) begin
                                bcnt  <= '0;
`ifdef ALU_SEQ_CHECKSUM_EN
                                state <= S_GET_CS;
`else
                                state <= S_EXEC;
`endif
                            end
                        end
`ifdef ALU_SEQ_CHECKSUM_EN
                        else begin
                            cs_bad <= (csx != rx_data);
                            state  <= S_EXEC;
                        end
`endif
                    end else if (idle == TW'(TIMEOUT - 1)) begin
                        // A byte arriving in the expiry cycle takes the branch above.
                        idle      <= '0;
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        idle <= idle + TW'(1);
                    end
                end
                S_EXEC: begin
                    res       <= alu_out;
                    tx_valid  <= 1'b1;
                    tx_data   <= err ? ERR_BYTE : alu_out[N-1 -: 8];
                    rem       <= err ? '0 : BW'(RB - 1);
                    frame_err <= err | rx_valid;
                    state     <= S_RESP;
`ifdef ALU_SEQ_CHECKSUM_EN
                    rcs       <= xor_bytes(alu_out);
`endif
                end
                S_RESP: begin
                    frame_err <= rx_valid;
                    if (tx_valid && tx_ready) begin
                        if (rem == '0) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            rem     <= rem - BW'(1);
                            res     <= nxt;
`ifdef ALU_SEQ_CHECKSUM_EN
                            tx_data <= (rem == BW'(1)) ? rcs : nxt[N-1 -: 8];
`else
                            tx_data <= nxt[N-1 -: 8];
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed frames plus random traffic.
// Reference ALU lives here; expected response bytes are queued as frames are sent.
module tb_alu_cmd_sequencer;

    localparam int N  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [3:0]   alu_opcode;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_out;
    logic         busy;
    logic         frame_err;

    int checks = 0;
    int failures = 0;
    int errcnt = 0;
    int exp_err = 0;
    int rdy_mode = 1;
    logic [7:0] exp_q[$];

    function automatic logic [15:0] alu_f(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << b[3:0];
            4'd6:    return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_a, alu_b);

    alu_cmd_sequencer #(
        .N(N), .TIMEOUT(TO), .MAX_OPCODE(6), .ERR_BYTE(8'hEE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = ($urandom_range(0, 2) != 0);
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expected byte per handshake, polices hold and error pulses.
    logic       held = 1'b0;
    logic [7:0] hold_d = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (frame_err) errcnt++;
            if (held) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(hold_d));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            held = tx_valid && !tx_ready;
            hold_d = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] b, input int gmax,
                              input int gfix, input bit bad_cs);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] r;
        bit          bad;
        bytes = {op, a[15:8], a[7:0], b[15:8], b[7:0]};
        bad = (op > 8'd6);
`ifdef ALU_SEQ_CHECKSUM_EN
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
        bytes.push_back(bad_cs ? (x ^ 8'hF0) : x);
        bad = bad || bad_cs;
`else
        x = {7'd0, bad_cs};
`endif
        if (bad) begin
            exp_q.push_back(8'hEE);
            exp_err++;
        end else begin
            r = alu_f(op[3:0], a, b);
            exp_q.push_back(r[15:8]);
            exp_q.push_back(r[7:0]);
`ifdef ALU_SEQ_CHECKSUM_EN
            exp_q.push_back(r[15:8] ^ r[7:0]);
`endif
        end
        foreach (bytes[i]) begin
            if (i == bytes.size() - 1)
                send_byte(bytes[i], 0);
            else if (gfix >= 0)
                send_byte(bytes[i], gfix);
            else
                send_byte(bytes[i], $urandom_range(0, gmax));
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL wait_done: got busy=%0d pending=%0d expected idle",
                     busy, exp_q.size());
        end
    endtask

    task automatic wait_txv();
        int n;
        n = 0;
        while (!tx_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_tx_valid", 32'(tx_valid), 32'd1);
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_alu", {alu_opcode, alu_a, 12'(alu_b)}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // AND, with exact response latency
        rdy_mode = 1;
        send_frame(8'h00, 16'hF0F0, 16'h0FFF, 0, 0, 1'b0);
        chk("lat_exec_no_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_tx_valid", 32'(tx_valid), 32'd1);
        chk("lat_first_byte", 32'(tx_data), 32'h00);
        wait_done();
        chk("busy_after", 32'(busy), 32'd0);

        // NOT; operands held after completion
        send_frame(8'h06, 16'h1234, 16'h0000, 2, -1, 1'b0);
        wait_done();
        chk("alu_a_hold", 32'(alu_a), 32'h1234);
        chk("alu_op_hold", 32'(alu_opcode), 32'h6);

        // bad opcode, then recovery
        send_frame(8'h09, 16'h1122, 16'h3344, 1, -1, 1'b0);
        wait_done();
        chk("bad_op_err", errcnt, exp_err);
        send_frame(8'h01, 16'h000F, 16'h00F0, 1, -1, 1'b0);
        wait_done();

        // timeout on partial frame
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        repeat (TO - 1) begin
            @(posedge clk);
            #1;
        end
        chk("to_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("to_busy_after", 32'(busy), 32'd0);
        exp_err++;
        @(posedge clk);
        #1;
        chk("to_err", errcnt, exp_err);
        send_frame(8'h02, 16'hFF00, 16'h0F0F, 0, -1, 1'b0);
        wait_done();

        // gaps of TIMEOUT-1: byte lands in the expiry cycle and wins
        send_frame(8'h03, 16'h1234, 16'h1111, 0, TO - 1, 1'b0);
        wait_done();
        chk("gap_boundary_err", errcnt, exp_err);

        // backpressure hold plus overrun byte during RESP
        rdy_mode = 2;
        send_frame(8'h04, 16'h5678, 16'h0123, 1, -1, 1'b0);
        wait_txv();
        send_byte(8'h5A, 0);
        exp_err++;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        wait_done();
        chk("overrun_err", errcnt, exp_err);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            op = 8'($urandom_range(0, 11));
            if (op == 8'd11) op = 8'hA2;
            ra = 16'($urandom);
            rb = 16'($urandom);
            send_frame(op, ra, rb, 3, -1, ($urandom_range(0, 5) == 0));
            wait_done();
        end
        chk("rand_err", errcnt, exp_err);

        // reset in the middle of a response
        rdy_mode = 2;
        send_frame(8'h05, 16'h0F0F, 16'h0004, 0, -1, 1'b0);
        wait_txv();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_alu", {alu_opcode, alu_a, 12'(alu_b)}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("post_rst_quiet", 32'(tx_valid), 32'd0);
        send_frame(8'h04, 16'h0010, 16'h0001, 1, -1, 1'b0);
        wait_done();

`ifdef ALU_SEQ_CHECKSUM_EN
        send_frame(8'h00, 16'hF0F0, 16'h0FFF, 0, -1, 1'b1);
        wait_done();
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("final_err", errcnt, exp_err);
        chk("final_queue", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
